serial_frame_tx: RTL and testbench

Serial frame transmitter that converts a parallel word into a single-bit line stream. Each frame is a 1-then-0 preamble, then data LSB-first, then an optional even-parity bit, then a low guard gap.
It drives the serial input of the downstream 1→0 sequence-detector FSM. That detector recognises the preamble and marks frame start.
Parallel side uses a valid/ready handshake.

---
 rtl/serial_frame_tx_pkg.sv | 37 +++
 rtl/frame_tx_shifter.sv | 75 +++++++
 rtl/serial_frame_tx.sv | 113 +++++++++++
 tb/tb_serial_frame_tx.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_tx_pkg
// Shared definitions for the serial frame transmitter:
//   state_e    - FSM state encoding (3-bit)
//   PRE_HI/LO  - preamble line levels (1 then 0)
//   frame_len  - number of line cycles one frame occupies
//   cnt_width  - width of the shared bit/gap counter
// -----------------------------------------------------------------------------
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE1   = 3'd1,
    PRE0   = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    GAP    = 3'd5
  } state_e;

  localparam logic PRE_HI = 1'b1;
  localparam logic PRE_LO = 1'b0;

  // Cycles on the line for one frame: preamble + data + optional parity + gap.
  function automatic int frame_len(input int data_w, input int parity_en,
                                   input int gap_len);
    return 2 + data_w + ((parity_en != 0) ? 1 : 0) + gap_len;
  endfunction

  // The counter serves both DATA and GAP, so it is sized for the longer one
  // plus a spare bit so it never wraps inside a state.
  function automatic int cnt_width(input int data_w, input int gap_len);
    int m;
    m = (data_w > gap_len) ? data_w : gap_len;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/frame_tx_shifter.sv
// -----------------------------------------------------------------------------
// frame_tx_shifter
// Datapath for serial_frame_tx: load/shift register, bit/gap counter and the
// parity of the latched word.
// Ports:
//   clk_i        clock, posedge
//   rst_ni       synchronous active-low reset (clears everything)
//   load_i       latch data_i into the shift register and capture its parity
//   shift_i      shift the register right by one (LSB goes out first)
//   cnt_clr_i    clear the counter (has priority over cnt_inc_i)
//   cnt_inc_i    increment the counter
//   data_i       parallel word to latch
//   next_bit_o   bit 0 of the shift register as it will be after this edge
//   parity_o     XOR of the latched word (even parity bit)
//   cnt_o        current counter value
//   cnt_next_o   counter value after this edge
// -----------------------------------------------------------------------------
module frame_tx_shifter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              cnt_clr_i,
  input  logic              cnt_inc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              next_bit_o,
  output logic              parity_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [CNT_W-1:0]  cnt_next_o
);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              parity_q, parity_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shreg_d  = shreg_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      shreg_d  = data_i;
      // Parity is captured at load because the register is consumed by shifting.
      parity_d = ^data_i;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
    end
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q  <= '0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
    end
  end

  // The line output is registered in the top, so it needs the post-edge bit.
  assign next_bit_o = shreg_d[0];
  assign parity_o   = parity_q;
  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Parallel-to-serial frame transmitter. Frame on the line: 1, 0 preamble,
// DATA_W data bits LSB first, optional even-parity bit, GAP_LEN low cycles.
// Ports:
//   CLK         clock, posedge
//   RST         synchronous active-low reset
//   tx_data     word to send, sampled on accept (tx_valid && tx_ready)
//   tx_valid    tx_data is valid
//   tx_ready    high only in IDLE (combinational from state register)
//   Out1        registered serial line
//   tx_busy     registered, high while a frame is in progress
//   frame_done  registered one-cycle pulse in the last GAP cycle
// -----------------------------------------------------------------------------
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP_LEN   = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              Out1,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_width(DATA_W, GAP_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_LEN - 1);

  state_e           state_q, state_d;
  logic             out1_q, out1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift, cnt_clr, cnt_inc;
  logic             next_bit, parity;
  logic [CNT_W-1:0] cnt, cnt_next;

  frame_tx_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (load),
    .shift_i    (shift),
    .cnt_clr_i  (cnt_clr),
    .cnt_inc_i  (cnt_inc),
    .data_i     (tx_data),
    .next_bit_o (next_bit),
    .parity_o   (parity),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (tx_valid) state_d = PRE1;
      PRE1:   state_d = PRE0;
      PRE0:   state_d = DATA;
      DATA:   if (cnt == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : GAP;
      PARITY: state_d = GAP;
      GAP:    if (cnt == LAST_GAP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state change, so DATA and GAP both count from 0.
  assign load    = (state_q == IDLE) && tx_valid;
  assign shift   = (state_q == DATA);
  assign cnt_clr = (state_d != state_q);
  assign cnt_inc = (state_q == DATA) || (state_q == GAP);

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    out1_d = 1'b0;
    unique case (state_d)
      PRE1:    out1_d = PRE_HI;
      PRE0:    out1_d = PRE_LO;
      DATA:    out1_d = next_bit;
      PARITY:  out1_d = parity;
      default: out1_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == GAP) && (cnt_next == LAST_GAP);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      out1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign Out1       = out1_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;
  import serial_frame_tx_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       out_a, out_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int checks_cnt = 0;
  int errors_cnt = 0;

  serial_frame_tx u_dut (
    .CLK        (clk),
    .RST        (rst),
    .tx_data    (data_a),
    .tx_valid   (valid_a),
    .tx_ready   (ready_a),
    .Out1       (out_a),
    .tx_busy    (busy_a),
    .frame_done (done_a)
  );

  serial_frame_tx #(
    .DATA_W    (8),
    .PARITY_EN (0),
    .GAP_LEN   (2)
  ) u_dut_np (
    .CLK        (clk),
    .RST        (rst),
    .tx_data    (data_b),
    .tx_valid   (valid_b),
    .tx_ready   (ready_b),
    .Out1       (out_b),
    .tx_busy    (busy_b),
    .frame_done (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 after the accept edge; walks the whole frame and ends
  // in the first IDLE cycle after it.
  task automatic check_frame(input logic sel, input logic [15:0] exp_bits,
                             input int nbits, input string tag);
    logic o, r, b, d;
    for (int k = 1; k <= nbits; k++) begin
      o = sel ? out_b : out_a;
      r = sel ? ready_b : ready_a;
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      check($sformatf("%s out c%0d", tag, k), 32'(o), 32'(exp_bits[nbits-k]));
      check($sformatf("%s ready c%0d", tag, k), 32'(r), 32'd0);
      check($sformatf("%s busy c%0d", tag, k), 32'(b), 32'd1);
      check($sformatf("%s done c%0d", tag, k), 32'(d), 32'(k == nbits));
      tick();
    end
    o = sel ? out_b : out_a;
    r = sel ? ready_b : ready_a;
    b = sel ? busy_b : busy_a;
    check($sformatf("%s ready end", tag), 32'(r), 32'd1);
    check($sformatf("%s busy end", tag), 32'(b), 32'd0);
    check($sformatf("%s out end", tag), 32'(o), 32'd0);
    $display("frame %s: %0d line cycles checked", tag, nbits);
  endtask

  task automatic send_a(input logic [7:0] d);
    data_a  = d;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    data_a  = 8'h00;
  endtask

  int  len_p, len_np;
  logic seen_done;

  initial begin
    len_p  = frame_len(8, 1, 2);
    len_np = frame_len(8, 0, 2);
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0; data_a = 8'h00; data_b = 8'h00;
    tick(); tick();
    check("rst out", 32'(out_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst ready", 32'(ready_a), 32'd1);
    rst = 1'b1;
    tick();
    $display("reset released");

    // A5: preamble, 1,0,1,0,0,1,0,1, parity 0, gap
    send_a(8'hA5);
    check_frame(1'b0, 16'b10_10100101_0_00, len_p, "A5");

    // 07: data 1,1,1,0,0,0,0,0, parity 1
    send_a(8'h07);
    check_frame(1'b0, 16'b10_11100000_1_00, len_p, "07");

    // No-parity instance, 01: 12-cycle frame
    data_b = 8'h01; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    check_frame(1'b1, 16'b10_10000000_00, len_np, "np01");

    // Valid held high: 3C accepted, C3 must wait for IDLE (14 cycles later)
    data_a = 8'h3C; valid_a = 1'b1;
    tick();
    data_a = 8'hC3;
    check_frame(1'b0, 16'b10_00111100_0_00, len_p, "3C");
    tick();
    valid_a = 1'b0;
    check_frame(1'b0, 16'b10_11000011_0_00, len_p, "C3");

    // Reset during data bit 3 of FF
    send_a(8'hFF);
    for (int k = 1; k < 6; k++) tick();
    check("FF bit3 out", 32'(out_a), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort out", 32'(out_a), 32'd0);
    check("abort ready", 32'(ready_a), 32'd1);
    check("abort busy", 32'(busy_a), 32'd0);
    seen_done = done_a;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen_done = seen_done | done_a | out_a;
    end
    check("abort quiet", 32'(seen_done), 32'd0);
    $display("frame FF aborted by reset");
    send_a(8'h00);
    check_frame(1'b0, 16'b10_00000000_0_00, len_p, "00");

    // Reset coincident with valid in IDLE: no accept
    rst = 1'b0; data_a = 8'hAA; valid_a = 1'b1;
    tick();
    check("rstv out", 32'(out_a), 32'd0);
    check("rstv busy", 32'(busy_a), 32'd0);
    rst = 1'b1; valid_a = 1'b0;
    tick();
    check("rstv out2", 32'(out_a), 32'd0);
    check("rstv busy2", 32'(busy_a), 32'd0);
    check("rstv ready", 32'(ready_a), 32'd1);
    $display("reset with valid: no accept");

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
